// File: rtl/unary_emitter_pkg.sv
// Shared state encoding for the count-to-bitstream emitter.
// The encoding is kept in a package so other blocks can decode the same codes.
package unary_emitter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ripple_decrementer.sv
// Combinational a-1 built from a chain of half-subtractor cells, plus a zero flag on a.
module ripple_decrementer #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] diff,
  output logic             zero
);

  // Borrow enters bit 0 as the constant 1 being subtracted.
  always_comb begin
    logic borrow;
    borrow = 1'b1;
    diff   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i] = a[i] ^ borrow;
      borrow  = ~a[i] & borrow;
    end
  end

  assign zero = ~|a;

endmodule

// File: rtl/unary_emitter.sv
// Converts a loaded count into that many consecutive 1s on out_bit, one per clock,
// followed by a single-cycle done pulse. pause stretches the burst; flush aborts it.
module unary_emitter
  import unary_emitter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_count,
  input  logic             pause,
  input  logic             flush,
  output logic             out_bit,
  output logic [WIDTH-1:0] remaining,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] remaining_next;
  logic [WIDTH-1:0] rem_dec;
  logic             rem_zero;
  logic             accept;

  ripple_decrementer #(.WIDTH(WIDTH)) u_dec (
    .a    (remaining),
    .diff (rem_dec),
    .zero (rem_zero)
  );

  // rst gates load_ready so every output reads zero while reset is held.
  assign load_ready = (state == ST_IDLE) & ~rst;
  assign accept     = load_valid & load_ready & ~flush;
  assign out_bit    = (state == ST_EMIT) & ~pause;
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          remaining_next = load_count;
          state_next     = (load_count != '0) ? ST_EMIT : ST_DONE;
        end
      end
      ST_EMIT: begin
        // Decrement only on an emitted 1; the zero guard prevents wrap-around.
        if (out_bit && !rem_zero) begin
          remaining_next = rem_dec;
          if (rem_dec == '0) state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        remaining_next = '0;
        state_next     = ST_IDLE;
      end
      default: begin
        remaining_next = '0;
        state_next     = ST_IDLE;
      end
    endcase
    if (flush) begin
      remaining_next = '0;
      state_next     = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
    end
  end

endmodule
